// File: rtl/debug_unit_pkg.sv
// ============================================================================
// debug_unit_pkg : command codes, frame header and FSM state encodings for
//                  the debug-unit dump engine.
// Revision       : 1.0
// ============================================================================
`default_nettype none

package debug_unit_pkg;

    localparam logic [7:0] CMD_RUN      = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STOP     = 8'h53;  // 'S'
    localparam logic [7:0] CMD_STEP     = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_DUMP     = 8'h44;  // 'D'
    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    // Words before the register block: header, PC, cycle count.
    localparam int PREFIX_WORDS = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STEP  = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SEND  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_CSUM  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/debug_unit_word_serializer.sv
// ============================================================================
// debug_unit_word_serializer : holds one dump word and presents it byte by
//                              byte in the configured order; flags last byte.
// Revision                   : 1.0
// ============================================================================
`default_nettype none

module debug_unit_word_serializer #(
    parameter int NB_DATA       = 32,
    parameter int NB_BYTE       = 8,
    parameter int LITTLE_ENDIAN = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               single,
    input  logic [NB_DATA-1:0] word,
    input  logic               advance,
    output logic [NB_BYTE-1:0] byte_out,
    output logic               last
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [NB_DATA-1:0] word_q;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   sel;
    logic               single_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q   <= '0;
            idx      <= '0;
            single_q <= 1'b0;
        end else if (load) begin
            word_q   <= word;
            idx      <= '0;
            single_q <= single;
        end else if (advance && !last) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // A single-byte word (the header) always lives in the low byte.
    assign sel  = (LITTLE_ENDIAN != 0) ? idx : IDX_W'(N_BYTES - 1) - idx;
    assign last = single_q || (idx == IDX_W'(N_BYTES - 1));

    always_comb begin
        byte_out = word_q[NB_BYTE-1:0];
        if (!single_q) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (sel == IDX_W'(b)) byte_out = word_q[b*NB_BYTE +: NB_BYTE];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/debug_unit_dump_engine.sv
// ============================================================================
// debug_unit_dump_engine : UART-side debug controller; decodes run/step/dump
//                          commands and streams a framed state dump.
//                          Optional trailing XOR checksum: DEBUG_UNIT_CHECKSUM_EN
// Revision               : 1.0
// ============================================================================
`default_nettype none

module debug_unit_dump_engine
    import debug_unit_pkg::*;
#(
    parameter int NB_DATA       = 32,
    parameter int NB_BYTE       = 8,
    parameter int N_REGISTERS   = 32,
    parameter int N_MEM_WORDS   = 32,
    parameter int NB_MEM_ADDR   = 5,
    parameter int LITTLE_ENDIAN = 0,
    parameter int NB_STATE      = 3
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [NB_BYTE-1:0]             i_rx_data,
    input  logic                           i_rx_done,
    output logic [NB_BYTE-1:0]             o_tx_data,
    output logic                           o_tx_start,
    input  logic                           i_tx_done,
    input  logic                           i_halt,
    input  logic [NB_DATA-1:0]             i_pc,
    input  logic [NB_DATA-1:0]             i_cycles,
    input  logic [N_REGISTERS*NB_DATA-1:0] i_registers,
    output logic [NB_MEM_ADDR-1:0]         o_mem_addr,
    input  logic [NB_DATA-1:0]             i_mem_data,
    output logic                           o_execution_mode,
    output logic                           o_execution_step,
    output logic                           o_du_done,
    output logic [NB_STATE-1:0]            o_state
);

    localparam int MEM_BASE = PREFIX_WORDS + N_REGISTERS;
    localparam int N_WORDS  = MEM_BASE + N_MEM_WORDS;
    localparam int WORD_W   = $clog2(N_WORDS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_WORDS - 1);

    state_t              state;
    logic [WORD_W-1:0]   word_idx;
    logic [WORD_W-1:0]   next_idx;
    logic                halt_q;
    logic [NB_DATA-1:0]  load_word;
    logic [NB_BYTE-1:0]  ser_byte;
    logic                ser_last;
    logic                ser_load;
    logic                ser_advance;
    logic                rx_run, rx_stop, rx_step, rx_dump;
    logic                dump_trigger;
`ifdef DEBUG_UNIT_CHECKSUM_EN
    logic [NB_BYTE-1:0]  csum;
    logic                csum_sent;
`endif

    assign rx_run       = i_rx_done && (i_rx_data == NB_BYTE'(CMD_RUN));
    assign rx_stop      = i_rx_done && (i_rx_data == NB_BYTE'(CMD_STOP));
    assign rx_step      = i_rx_done && (i_rx_data == NB_BYTE'(CMD_STEP));
    assign rx_dump      = i_rx_done && (i_rx_data == NB_BYTE'(CMD_DUMP));
    assign dump_trigger = rx_dump || (i_halt && !halt_q && o_execution_mode);

    assign next_idx    = word_idx + WORD_W'(1);
    assign ser_load    = (state == ST_LOAD);
    assign ser_advance = (state == ST_WAIT) && i_tx_done && !ser_last;
    assign o_state     = NB_STATE'(state);

    // Registers are sampled at the moment their own word is loaded.
    always_comb begin
        load_word = i_mem_data;
        if (word_idx == '0)               load_word = NB_DATA'(FRAME_HEADER);
        else if (word_idx == WORD_W'(1))  load_word = i_pc;
        else if (word_idx == WORD_W'(2))  load_word = i_cycles;
        for (int i = 0; i < N_REGISTERS; i++) begin
            if (word_idx == WORD_W'(i + PREFIX_WORDS))
                load_word = i_registers[i*NB_DATA +: NB_DATA];
        end
    end

    debug_unit_word_serializer #(
        .NB_DATA       (NB_DATA),
        .NB_BYTE       (NB_BYTE),
        .LITTLE_ENDIAN (LITTLE_ENDIAN)
    ) u_serializer (
        .clk      (i_clock),
        .rst      (i_reset),
        .load     (ser_load),
        .single   (word_idx == '0),
        .word     (load_word),
        .advance  (ser_advance),
        .byte_out (ser_byte),
        .last     (ser_last)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state            <= ST_IDLE;
            word_idx         <= '0;
            halt_q           <= 1'b0;
            o_tx_data        <= '0;
            o_tx_start       <= 1'b0;
            o_mem_addr       <= '0;
            o_execution_mode <= 1'b0;
            o_execution_step <= 1'b0;
            o_du_done        <= 1'b0;
`ifdef DEBUG_UNIT_CHECKSUM_EN
            csum             <= '0;
            csum_sent        <= 1'b0;
`endif
        end else begin
            halt_q           <= i_halt;
            o_tx_start       <= 1'b0;
            o_execution_step <= 1'b0;
            o_du_done        <= 1'b0;
            if (rx_run)       o_execution_mode <= 1'b1;
            else if (rx_stop) o_execution_mode <= 1'b0;

            case (state)
                ST_IDLE: begin
                    word_idx <= '0;
`ifdef DEBUG_UNIT_CHECKSUM_EN
                    csum      <= '0;
                    csum_sent <= 1'b0;
`endif
                    if (rx_step && !o_execution_mode) begin
                        o_execution_step <= 1'b1;
                        state            <= ST_STEP;
                    end else if (dump_trigger) begin
                        state <= ST_LOAD;
                    end
                end
                ST_STEP:  state <= ST_LOAD;
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD:  state <= ST_SEND;
                ST_SEND: begin
                    o_tx_data  <= ser_byte;
                    o_tx_start <= 1'b1;
`ifdef DEBUG_UNIT_CHECKSUM_EN
                    if (word_idx != '0) csum <= csum ^ ser_byte;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (!ser_last) begin
                            state <= ST_SEND;
                        end else if (word_idx != LAST_WORD) begin
                            word_idx <= next_idx;
                            if (int'(next_idx) >= MEM_BASE) begin
                                o_mem_addr <= NB_MEM_ADDR'(int'(next_idx) - MEM_BASE);
                                state      <= ST_FETCH;
                            end else begin
                                state <= ST_LOAD;
                            end
                        end else begin
`ifdef DEBUG_UNIT_CHECKSUM_EN
                            state <= csum_sent ? ST_DONE : ST_CSUM;
`else
                            state <= ST_DONE;
`endif
                        end
                    end
                end
                ST_CSUM: begin
`ifdef DEBUG_UNIT_CHECKSUM_EN
                    o_tx_data  <= csum;
                    o_tx_start <= 1'b1;
                    csum_sent  <= 1'b1;
                    state      <= ST_WAIT;
`else
                    state <= ST_IDLE;
`endif
                end
                ST_DONE: begin
                    o_du_done <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_debug_unit_dump_engine.sv
// ============================================================================
// tb_debug_unit_dump_engine : scoreboard bench for the dump engine with a
//                             byte-level UART responder and memory model.
// Revision                  : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_debug_unit_dump_engine;

    localparam int NREG = 32;
    localparam int NMEM = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_data = '0;
    logic             rx_done = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_done = 1'b0;
    logic             halt = 1'b0;
    logic [31:0]      pc = '0;
    logic [31:0]      cycles = '0;
    logic [NREG*32-1:0] registers;
    logic [4:0]       mem_addr;
    logic [31:0]      mem_rd = '0;
    logic             exec_mode;
    logic             exec_step;
    logic             du_done;
    logic [2:0]       state;

    logic [31:0] regs [NREG];
    logic [31:0] mem  [NMEM];
    logic [7:0]  exp_q [$];

    int checks = 0;
    int errors = 0;
    int rx_bytes = 0;
    int done_cnt = 0;
    int step_cnt = 0;
    int frames = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREG; g++) begin : g_regs
        assign registers[g*32 +: 32] = regs[g];
    end

    always @(posedge clk) mem_rd <= mem[mem_addr];

    debug_unit_dump_engine dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_rx_data        (rx_data),
        .i_rx_done        (rx_done),
        .o_tx_data        (tx_data),
        .o_tx_start       (tx_start),
        .i_tx_done        (tx_done),
        .i_halt           (halt),
        .i_pc             (pc),
        .i_cycles         (cycles),
        .i_registers      (registers),
        .o_mem_addr       (mem_addr),
        .i_mem_data       (mem_rd),
        .o_execution_mode (exec_mode),
        .o_execution_step (exec_step),
        .o_du_done        (du_done),
        .o_state          (state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference frame: header, then every word MSB byte first, then the
    // optional XOR of everything after the header.
    task automatic push_frame();
        logic [31:0] words [$];
        logic [7:0]  sum;
        logic [7:0]  b;
        sum = 8'h00;
        words.push_back(pc);
        words.push_back(cycles);
        foreach (regs[i]) words.push_back(regs[i]);
        foreach (mem[j])  words.push_back(mem[j]);
        exp_q.push_back(8'hA5);
        foreach (words[w]) begin
            for (int k = 3; k >= 0; k--) begin
                b = words[w][8*k +: 8];
                exp_q.push_back(b);
                sum = sum ^ b;
            end
        end
`ifdef DEBUG_UNIT_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    task automatic randomize_state();
        pc     = $urandom;
        cycles = $urandom;
        foreach (regs[i]) regs[i] = $urandom;
        foreach (mem[j])  mem[j]  = $urandom;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("du_done_count", done_cnt, target);
        check("frame_bytes_left", exp_q.size(), 0);
    endtask

    task automatic wait_bytes(input int target);
        int n;
        n = 0;
        while (rx_bytes < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (rx_bytes < target) begin
            checks++;
            errors++;
            $display("FAIL byte_wait_timeout: got %0d bytes required %0d", rx_bytes, target);
        end
    endtask

    // UART responder and scoreboard monitor.
    initial begin
        logic [7:0] sent;
        int         dly;
        forever begin
            @(negedge clk);
            if (tx_start && !rst) begin
                rx_bytes++;
                sent = tx_data;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_byte: got unexpected %02h required none", tx_data);
                end else begin
                    check("frame_byte", tx_data, exp_q.pop_front());
                end
                dly = $urandom_range(0, 3);
                for (int d = 0; d < dly; d++) begin
                    @(negedge clk);
                    check("no_restart_before_done", tx_start, 1'b0);
                end
                check("tx_data_stable", tx_data, sent);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (exec_step) step_cnt++;
            if (du_done)   done_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        int base;
        foreach (regs[i]) regs[i] = '0;
        foreach (mem[j])  mem[j]  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_start", tx_start, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_mode", exec_mode, 0);
        check("reset_step", exec_step, 0);
        check("reset_du_done", du_done, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_state", state, 0);
        rst = 1'b0;

        // Known register / memory pattern.
        pc     = $urandom;
        cycles = $urandom;
        foreach (regs[i]) regs[i] = i;
        foreach (mem[j])  mem[j]  = 32'h100 + j;
        push_frame();
        send_byte(8'h44);
        wait_done(++frames);

        // Step command produces exactly one step pulse and a dump.
        send_byte(8'h53);
        check("mode_after_S", exec_mode, 0);
        pc = 32'h40;
        s0 = step_cnt;
        push_frame();
        send_byte(8'h4E);
        wait_done(++frames);
        check("step_pulse_cycles", step_cnt - s0, 1);

        // Halt rising edge in run mode; held halt must not refire.
        randomize_state();
        send_byte(8'h43);
        check("mode_after_C", exec_mode, 1);
        push_frame();
        @(negedge clk);
        halt = 1'b1;
        wait_done(++frames);
        repeat (400) @(negedge clk);
        check("held_halt_no_refire", done_cnt, frames);
        halt = 1'b0;

        // Commands arriving mid-dump.
        randomize_state();
        push_frame();
        base = rx_bytes;
        s0   = step_cnt;
        send_byte(8'h44);
        wait_bytes(base + 20);
        send_byte(8'h53);
        check("mode_S_mid_dump", exec_mode, 0);
        send_byte(8'h4E);
        send_byte(8'h44);
        wait_done(++frames);
        check("no_step_mid_dump", step_cnt - s0, 0);
        repeat (300) @(negedge clk);
        check("single_frame_mid_dump", done_cnt, frames);

        // Reset in the middle of a dump, then a fresh full frame.
        send_byte(8'h43);
        randomize_state();
        push_frame();
        base = rx_bytes;
        send_byte(8'h44);
        wait_bytes(base + 10);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_tx_start", tx_start, 0);
        check("midreset_tx_data", tx_data, 0);
        check("midreset_mode", exec_mode, 0);
        check("midreset_mem_addr", mem_addr, 0);
        check("midreset_state", state, 0);
        exp_q.delete();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        randomize_state();
        push_frame();
        send_byte(8'h44);
        wait_done(++frames);

        // All-zero state, then a single nonzero register byte.
        pc     = '0;
        cycles = '0;
        foreach (regs[i]) regs[i] = '0;
        foreach (mem[j])  mem[j]  = '0;
        push_frame();
        send_byte(8'h44);
        wait_done(++frames);
        regs[1] = 32'hFF;
        push_frame();
        send_byte(8'h44);
        wait_done(++frames);

        // Random frames.
        for (int r = 0; r < 2; r++) begin
            randomize_state();
            push_frame();
            send_byte(8'h44);
            wait_done(++frames);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
